// File: rtl/maze_dfs_walker.sv
// Depth-first maze solver over an external 1-bit maze memory; keeps the path on an indexed
// stack and replays it over valid/ready. Define STEP_COUNT_EN to add the saturating `steps` output.
module maze_dfs_walker #(
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int DEPTH  = 256,
  parameter int GOAL_X = 2**XW-1,
  parameter int GOAL_Y = 2**YW-1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [XW-1:0]              start_x,
  input  logic [YW-1:0]              start_y,
  output logic [XW-1:0]              mem_x,
  output logic [YW-1:0]              mem_y,
  output logic                       mem_rd,
  input  logic                       mem_rdata,
  output logic                       mem_wr,
  output logic                       busy,
  output logic                       found,
  output logic                       fail,
  output logic [$clog2(DEPTH+1)-1:0] path_len,
  output logic                       path_valid,
  input  logic                       path_ready,
  output logic [1:0]                 path_dir,
  output logic                       path_last
`ifdef STEP_COUNT_EN
  ,
  output logic [15:0]                steps
`endif
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XW-1:0] GX   = XW'(GOAL_X);
  localparam logic [YW-1:0] GY   = YW'(GOAL_Y);
  localparam logic [XW-1:0] XMAX = '1;
  localparam logic [YW-1:0] YMAX = '1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_MARK, S_PROBE, S_CHECK, S_ADVANCE, S_BACK, S_REPLAY, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, nbr_x;
  logic [YW-1:0]   y_q, y_d, nbr_y;
  logic [1:0]      dir_q, dir_d, top_dir;
  logic [LW-1:0]   len_q, len_d, idx_q, idx_d, top_idx;
  logic            blk_q, blk_d;
  logic            found_q, found_d;
  logic            fail_q, fail_d;
  logic            nbr_out;
  logic            push_en;
  logic [1:0]      stack_q [DEPTH];

  assign top_idx = len_q - 1'b1;
  assign top_dir = stack_q[top_idx[IW-1:0]];

  // Neighbour in the current probe direction; edge tests happen before any arithmetic.
  always_comb begin
    nbr_x   = x_q;
    nbr_y   = y_q;
    nbr_out = 1'b0;
    case (dir_q)
      2'd0: if (y_q == '0)   nbr_out = 1'b1; else nbr_y = y_q - 1'b1;
      2'd1: if (x_q == XMAX) nbr_out = 1'b1; else nbr_x = x_q + 1'b1;
      2'd2: if (y_q == YMAX) nbr_out = 1'b1; else nbr_y = y_q + 1'b1;
      default: if (x_q == '0) nbr_out = 1'b1; else nbr_x = x_q - 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    len_d   = len_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    found_d = found_q;
    fail_d  = fail_q;
    push_en = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    mem_x   = '0;
    mem_y   = '0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          x_d     = start_x;
          y_d     = start_y;
          dir_d   = 2'd0;
          len_d   = '0;
          idx_d   = '0;
          found_d = 1'b0;
          fail_d  = 1'b0;
          if (start_x == GX && start_y == GY) begin
            found_d = 1'b1;
            state_d = S_REPLAY;
          end else begin
            state_d = S_MARK;
          end
        end
      end
      S_MARK: begin
        mem_wr  = 1'b1;
        mem_x   = x_q;
        mem_y   = y_q;
        state_d = S_PROBE;
      end
      S_PROBE: begin
        state_d = S_CHECK;
        if (nbr_out || len_q == FULL) begin
          blk_d = 1'b1;
        end else begin
          blk_d  = 1'b0;
          mem_rd = 1'b1;
          mem_x  = nbr_x;
          mem_y  = nbr_y;
        end
      end
      S_CHECK: begin
        if (blk_q || mem_rdata) begin
          if (dir_q == 2'd3) begin
            state_d = S_BACK;
          end else begin
            dir_d   = dir_q + 2'd1;
            state_d = S_PROBE;
          end
        end else begin
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        push_en = 1'b1;
        x_d     = nbr_x;
        y_d     = nbr_y;
        dir_d   = 2'd0;
        len_d   = len_q + 1'b1;
        if (nbr_x == GX && nbr_y == GY) begin
          found_d = 1'b1;
          state_d = S_REPLAY;
        end else begin
          state_d = S_MARK;
        end
      end
      S_BACK: begin
        if (len_q == '0) begin
          state_d = S_FAIL;
        end else begin
          // Undo the move on top of the stack and resume with the next direction.
          len_d = top_idx;
          dir_d = top_dir + 2'd1;
          case (top_dir)
            2'd0:    y_d = y_q + 1'b1;
            2'd1:    x_d = x_q - 1'b1;
            2'd2:    y_d = y_q - 1'b1;
            default: x_d = x_q + 1'b1;
          endcase
          if (top_dir != 2'd3) state_d = S_PROBE;
        end
      end
      S_FAIL: begin
        fail_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_REPLAY: begin
        if (len_q == '0) begin
          state_d = S_IDLE;
        end else if (path_ready) begin
          if (idx_q == top_idx) state_d = S_IDLE;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= 2'd0;
      len_q   <= '0;
      idx_q   <= '0;
      blk_q   <= 1'b0;
      found_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      found_q <= found_d;
      fail_q  <= fail_d;
    end
  end

  // Stack contents are qualified by len_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[len_q[IW-1:0]] <= dir_q;
  end

  assign busy       = (state_q != S_IDLE);
  assign found      = found_q;
  assign fail       = fail_q;
  assign path_len   = len_q;
  assign path_valid = (state_q == S_REPLAY) && (len_q != '0);
  assign path_dir   = path_valid ? stack_q[idx_q[IW-1:0]] : 2'd0;
  assign path_last  = path_valid && (idx_q == top_idx);

`ifdef STEP_COUNT_EN
  logic [15:0] steps_q, steps_d;
  logic        step_evt;

  assign step_evt = (state_q == S_ADVANCE) || (state_q == S_BACK && len_q != '0);

  always_comb begin
    steps_d = steps_q;
    if (state_q == S_IDLE && go)                 steps_d = '0;
    else if (step_evt && steps_q != 16'hFFFF)    steps_d = steps_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) steps_q <= '0;
    else     steps_q <= steps_d;
  end

  assign steps = steps_q;
`endif

endmodule

// File: tb/tb_maze_dfs_walker.sv
// Bench for maze_dfs_walker on a 4x4 grid: a deep-stack instance and a DEPTH=4 instance
// share one maze memory model; results are compared with a software DFS reference.
module tb_maze_dfs_walker;

  logic        clk = 1'b0;
  logic        rst, go, sel, path_ready, load;
  logic [1:0]  start_x, start_y;
  logic [15:0] mem = 16'h0, maze_cfg;
  logic        mem_rdata = 1'b0;
  int          overlap = 0;

  logic [1:0]  mem_x_a, mem_y_a, mem_x_b, mem_y_b, path_dir_a, path_dir_b;
  logic        mem_rd_a, mem_wr_a, busy_a, found_a, fail_a, path_valid_a, path_last_a;
  logic        mem_rd_b, mem_wr_b, busy_b, found_b, fail_b, path_valid_b, path_last_b;
  logic [8:0]  path_len_a;
  logic [2:0]  path_len_b;

  logic [1:0]  mem_x, mem_y, path_dir;
  logic        mem_rd, mem_wr, busy, found, fail, path_valid, path_last;
  logic [8:0]  path_len;

  int checks = 0;
  int errors = 0;

  logic [1:0]  got_dirs[$];
  logic        got_last[$];
  int          exp_dirs[$];
  logic [15:0] exp_vis;
  bit          exp_found;
  int          exp_steps;
  bit          saw_valid, timed_out;
  int          stall_errs, found_lat;

`ifdef STEP_COUNT_EN
  logic [15:0] steps_a, steps_b, steps, got_steps;
  assign steps = sel ? steps_b : steps_a;
`endif

  always #5 clk = ~clk;

  assign mem_x      = sel ? mem_x_b      : mem_x_a;
  assign mem_y      = sel ? mem_y_b      : mem_y_a;
  assign mem_rd     = sel ? mem_rd_b     : mem_rd_a;
  assign mem_wr     = sel ? mem_wr_b     : mem_wr_a;
  assign busy       = sel ? busy_b       : busy_a;
  assign found      = sel ? found_b      : found_a;
  assign fail       = sel ? fail_b       : fail_a;
  assign path_valid = sel ? path_valid_b : path_valid_a;
  assign path_dir   = sel ? path_dir_b   : path_dir_a;
  assign path_last  = sel ? path_last_b  : path_last_a;
  assign path_len   = sel ? 9'(path_len_b) : path_len_a;

  maze_dfs_walker #(.XW(2), .YW(2), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .go(go & ~sel), .start_x(start_x), .start_y(start_y),
    .mem_x(mem_x_a), .mem_y(mem_y_a), .mem_rd(mem_rd_a), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr_a), .busy(busy_a), .found(found_a), .fail(fail_a),
    .path_len(path_len_a), .path_valid(path_valid_a), .path_ready(path_ready),
    .path_dir(path_dir_a), .path_last(path_last_a)
`ifdef STEP_COUNT_EN
    , .steps(steps_a)
`endif
  );

  maze_dfs_walker #(.XW(2), .YW(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .go(go & sel), .start_x(start_x), .start_y(start_y),
    .mem_x(mem_x_b), .mem_y(mem_y_b), .mem_rd(mem_rd_b), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr_b), .busy(busy_b), .found(found_b), .fail(fail_b),
    .path_len(path_len_b), .path_valid(path_valid_b), .path_ready(path_ready),
    .path_dir(path_dir_b), .path_last(path_last_b)
`ifdef STEP_COUNT_EN
    , .steps(steps_b)
`endif
  );

  // Maze memory: one-cycle read latency, writes set the visited bit.
  always @(posedge clk) begin
    if (load) begin
      mem <= maze_cfg;
    end else begin
      if (mem_rd) mem_rdata <= mem[{mem_y, mem_x}];
      if (mem_wr) mem[{mem_y, mem_x}] <= 1'b1;
    end
    if (mem_rd && mem_wr) overlap <= overlap + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int dx_of(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int dy_of(input int d);
    return (d == 2) ? 1 : (d == 0) ? -1 : 0;
  endfunction

  // Reference: plain DFS with permanent visited marks, neighbour order up/right/down/left.
  task automatic model_dfs(input int sx, input int sy, input int depth);
    int cx, cy, d, nx, ny, back;
    bit done;
    exp_dirs.delete();
    exp_vis = maze_cfg; exp_found = 0; exp_steps = 0;
    cx = sx; cy = sy; d = 0; done = 0;
    if (sx == 3 && sy == 3) begin exp_found = 1; done = 1; end
    else exp_vis[cy*4+cx] = 1'b1;
    while (!done) begin
      if (d < 4) begin
        nx = cx + dx_of(d); ny = cy + dy_of(d);
        if (nx >= 0 && nx < 4 && ny >= 0 && ny < 4 && exp_dirs.size() < depth
            && exp_vis[ny*4+nx] == 1'b0) begin
          exp_dirs.push_back(d); exp_steps++;
          cx = nx; cy = ny; d = 0;
          if (cx == 3 && cy == 3) begin exp_found = 1; done = 1; end
          else exp_vis[cy*4+cx] = 1'b1;
        end else begin
          d++;
        end
      end else if (exp_dirs.size() == 0) begin
        done = 1;
      end else begin
        back = exp_dirs.pop_back(); exp_steps++;
        cx -= dx_of(back); cy -= dy_of(back); d = back + 1;
      end
    end
  endtask

  function automatic int move_diffs();
    int n = 0;
    if (got_dirs.size() != exp_dirs.size()) return 99;
    foreach (got_dirs[i]) if (int'(got_dirs[i]) != exp_dirs[i]) n++;
    return n;
  endfunction

  function automatic int last_errs();
    int n = 0;
    foreach (got_last[i]) if (got_last[i] !== (i == got_last.size() - 1)) n++;
    return n;
  endfunction

  function automatic bit lands_on_goal(input int sx, input int sy);
    int x = sx, y = sy;
    foreach (got_dirs[i]) begin x += dx_of(int'(got_dirs[i])); y += dy_of(int'(got_dirs[i])); end
    return (x == 3 && y == 3);
  endfunction

  task automatic load_maze(input logic [15:0] m);
    @(negedge clk); maze_cfg = m; load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // rmode: 0 ready always high, 1 ready toggling, 2 ready random. inject pulses go mid-search.
  task automatic run_search(input int sx, input int sy, input int rmode, input bit inject);
    int cyc;
    bit r, prev_stall;
    logic [1:0] prev_dir;
    logic prev_last;
    got_dirs.delete(); got_last.delete();
    saw_valid = 0; timed_out = 0; stall_errs = 0; found_lat = -1; prev_stall = 0;
    prev_dir = 2'd0; prev_last = 1'b0;
    @(negedge clk); start_x = 2'(sx); start_y = 2'(sy); go = 1'b1;
    @(negedge clk); go = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 4000) begin
      if (found === 1'b1 && found_lat < 0) found_lat = cyc;
      if (prev_stall && (path_valid !== 1'b1 || path_dir !== prev_dir || path_last !== prev_last))
        stall_errs++;
      if (inject && cyc == 3) begin go = 1'b1; start_x = 2'd3; start_y = 2'd3; end
      else go = 1'b0;
      case (rmode)
        0:       r = 1'b1;
        1:       r = cyc[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      path_ready = r;
      if (path_valid === 1'b1) saw_valid = 1;
      if (path_valid === 1'b1 && r) begin got_dirs.push_back(path_dir); got_last.push_back(path_last); end
      prev_stall = (path_valid === 1'b1) && !r;
      prev_dir = path_dir; prev_last = path_last;
      @(negedge clk); cyc++;
    end
    go = 1'b0; path_ready = 1'b0;
    if (busy !== 1'b0) timed_out = 1;
`ifdef STEP_COUNT_EN
    got_steps = steps;
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (found !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL reset_flags: got found=%b fail=%b want 0/0", found, fail); end
    checks++; if (path_len !== 9'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", path_len); end
    checks++; if ({path_valid, path_last, path_dir} !== 4'b0) begin errors++; $display("FAIL reset_replay: got %b want 0000", {path_valid, path_last, path_dir}); end
    checks++; if ({mem_rd, mem_wr, mem_x, mem_y} !== 6'b0) begin errors++; $display("FAIL reset_mem: got %b want 000000", {mem_rd, mem_wr, mem_x, mem_y}); end
    rst = 1'b0;
  endtask

  task automatic test_open_grid();
    int tbl[6] = '{1, 1, 1, 2, 2, 2};
    int bad = 0;
    load_maze(16'h0000);
    run_search(0, 0, 0, 0);
    model_dfs(0, 0, 256);
    foreach (tbl[i]) if (i >= got_dirs.size() || int'(got_dirs[i]) != tbl[i]) bad++;
    checks++; if (found !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL open_flags: got found=%b fail=%b want 1/0", found, fail); end
    checks++; if (path_len !== 9'd6) begin errors++; $display("FAIL open_len: got %0d want 6", path_len); end
    checks++; if (got_dirs.size() != 6 || bad != 0) begin errors++; $display("FAIL open_moves: got %0d moves with %0d wrong, want R,R,R,D,D,D", got_dirs.size(), bad); end
    checks++; if (last_errs() != 0) begin errors++; $display("FAIL open_last: got %0d misplaced last flags want 0", last_errs()); end
    checks++; if (mem !== exp_vis) begin errors++; $display("FAIL open_marks: got %h want %h", mem, exp_vis); end
`ifdef STEP_COUNT_EN
    checks++; if (int'(got_steps) != exp_steps) begin errors++; $display("FAIL open_steps: got %0d want %0d", got_steps, exp_steps); end
`endif
  endtask

  task automatic test_wall_column();
    load_maze(16'h0222);
    run_search(0, 0, 0, 0);
    model_dfs(0, 0, 256);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL wall_found: got %b want 1", found); end
    checks++; if (!lands_on_goal(0, 0)) begin errors++; $display("FAIL wall_endpoint: got replay not ending at goal, want (3,3)"); end
    checks++; if (move_diffs() != 0 || int'(path_len) != exp_dirs.size()) begin errors++; $display("FAIL wall_moves: got len %0d diffs %0d want len %0d diffs 0", path_len, move_diffs(), exp_dirs.size()); end
    checks++; if (mem !== exp_vis) begin errors++; $display("FAIL wall_marks: got %h want %h", mem, exp_vis); end
  endtask

  task automatic test_enclosed_goal();
    load_maze(16'h4800);
    run_search(0, 0, 0, 0);
    model_dfs(0, 0, 256);
    checks++; if (timed_out) begin errors++; $display("FAIL encl_busy: got busy stuck high want busy to fall"); end
    checks++; if (fail !== 1'b1 || found !== 1'b0) begin errors++; $display("FAIL encl_flags: got fail=%b found=%b want 1/0", fail, found); end
    checks++; if (path_len !== 9'd0 || saw_valid) begin errors++; $display("FAIL encl_replay: got len=%0d valid_seen=%0d want 0/0", path_len, saw_valid); end
    checks++; if (mem !== exp_vis) begin errors++; $display("FAIL encl_marks: got %h want %h", mem, exp_vis); end
  endtask

  task automatic test_start_is_goal();
    load_maze(16'h0000);
    run_search(3, 3, 0, 0);
    checks++; if (found_lat < 0 || found_lat > 1) begin errors++; $display("FAIL sg_latency: got found at cycle %0d want 0..1", found_lat); end
    checks++; if (found !== 1'b1 || path_len !== 9'd0) begin errors++; $display("FAIL sg_result: got found=%b len=%0d want 1/0", found, path_len); end
    checks++; if (saw_valid) begin errors++; $display("FAIL sg_valid: got path_valid asserted want never"); end
  endtask

  task automatic test_depth_limit();
    sel = 1'b1;
    load_maze(16'h0000);
    run_search(0, 0, 0, 0);
    model_dfs(0, 0, 4);
    checks++; if (fail !== 1'b1 || found !== 1'b0) begin errors++; $display("FAIL depth_flags: got fail=%b found=%b want 1/0", fail, found); end
    checks++; if (path_len !== 9'd0 || saw_valid) begin errors++; $display("FAIL depth_replay: got len=%0d valid_seen=%0d want 0/0", path_len, saw_valid); end
    checks++; if (mem !== exp_vis) begin errors++; $display("FAIL depth_marks: got %h want %h", mem, exp_vis); end
    sel = 1'b0;
  endtask

  task automatic test_ready_toggle();
    load_maze(16'h0000);
    run_search(0, 0, 1, 0);
    model_dfs(0, 0, 256);
    checks++; if (stall_errs != 0) begin errors++; $display("FAIL toggle_stable: got %0d unstable stalls want 0", stall_errs); end
    checks++; if (move_diffs() != 0) begin errors++; $display("FAIL toggle_moves: got %0d moves %0d diffs want %0d moves 0 diffs", got_dirs.size(), move_diffs(), exp_dirs.size()); end
    checks++; if (last_errs() != 0) begin errors++; $display("FAIL toggle_last: got %0d misplaced last flags want 0", last_errs()); end
  endtask

  task automatic test_go_ignored();
    load_maze(16'h0222);
    run_search(0, 0, 0, 1);
    model_dfs(0, 0, 256);
    checks++; if (found !== 1'b1 || move_diffs() != 0) begin errors++; $display("FAIL busy_go: got found=%b diffs=%0d want 1/0", found, move_diffs()); end
  endtask

  task automatic test_random();
    int sx, sy;
    logic [15:0] m;
    for (int it = 0; it < 12; it++) begin
      sx = $urandom_range(0, 3); sy = $urandom_range(0, 3);
      m = 16'($urandom & $urandom);
      m[sy*4+sx] = 1'b0;
      load_maze(m);
      run_search(sx, sy, 2, 0);
      model_dfs(sx, sy, 256);
      checks++; if (timed_out || found !== exp_found || fail !== !exp_found) begin errors++; $display("FAIL rand%0d_flags: got found=%b fail=%b want found=%b", it, found, fail, exp_found); end
      checks++; if (int'(path_len) != exp_dirs.size() || move_diffs() != 0) begin errors++; $display("FAIL rand%0d_path: got len=%0d diffs=%0d want len=%0d", it, path_len, move_diffs(), exp_dirs.size()); end
      checks++; if (mem !== exp_vis || stall_errs != 0) begin errors++; $display("FAIL rand%0d_marks: got %h stalls=%0d want %h stalls=0", it, mem, stall_errs, exp_vis); end
`ifdef STEP_COUNT_EN
      checks++; if (int'(got_steps) != exp_steps) begin errors++; $display("FAIL rand%0d_steps: got %0d want %0d", it, got_steps, exp_steps); end
`endif
    end
  endtask

  task automatic test_reset_mid_replay();
    int cyc = 0;
    load_maze(16'h0000);
    @(negedge clk); start_x = 2'd0; start_y = 2'd0; go = 1'b1; path_ready = 1'b0;
    @(negedge clk); go = 1'b0;
    while (path_valid !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
    checks++; if (path_valid !== 1'b1) begin errors++; $display("FAIL rstrep_reach: got no replay within 500 cycles want replay"); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (busy !== 1'b0 || path_valid !== 1'b0) begin errors++; $display("FAIL rstrep_idle: got busy=%b valid=%b want 0/0", busy, path_valid); end
    checks++; if (path_len !== 9'd0 || found !== 1'b0) begin errors++; $display("FAIL rstrep_clear: got len=%0d found=%b want 0/0", path_len, found); end
  endtask

  task automatic test_strobe_exclusive();
    checks++; if (overlap != 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles with rd and wr want 0", overlap); end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; sel = 1'b0; path_ready = 1'b0; load = 1'b0;
    start_x = 2'd0; start_y = 2'd0; maze_cfg = 16'h0;
    test_reset();
    test_open_grid();
    test_wall_column();
    test_enclosed_goal();
    test_start_is_goal();
    test_depth_limit();
    test_ready_toggle();
    test_go_ignored();
    test_random();
    test_reset_mid_replay();
    test_strobe_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
